// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode constants and the responder state type for the
//               mips core and its load/store/stack responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [7:0] OP_NOOP = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_LDNM = 8'h02;
    localparam logic [7:0] OP_STR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_SUB  = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_JMP  = 8'h08;
    localparam logic [7:0] OP_JMP0 = 8'h09;
    localparam logic [7:0] OP_PUSH = 8'h0A;
    localparam logic [7:0] OP_POP  = 8'h0B;

    // Responder handshake state: waiting for a request, or holding a response
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_stack.sv
`default_nettype none
// ============================================================================
// Module      : mips_stack
// Description : Hardware LIFO with an extra-bit stack pointer so full and
//               empty are distinct. Push on full / pop on empty are refused
//               and flagged; the top-of-stack word is read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_stack #(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DATA_W-1:0]              push_data,
    output logic [DATA_W-1:0]              top_data,
    output logic                           push_err,
    output logic                           pop_err,
    output logic [$clog2(STACK_DEPTH):0]   count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_stack [STACK_DEPTH];
    logic [CNT_W-1:0]  r_sp;
    logic [CNT_W-1:0]  w_sp_m1;
    logic [PTR_W-1:0]  w_top_idx;

    assign w_sp_m1   = r_sp - CNT_W'(1);
    assign w_top_idx = w_sp_m1[PTR_W-1:0];

    assign full      = (r_sp == CNT_W'(STACK_DEPTH));
    assign empty     = (r_sp == '0);
    assign count     = r_sp;
    assign push_err  = push & full;
    assign pop_err   = pop & empty;
    assign top_data  = empty ? '0 : r_stack[w_top_idx];

    // Commit push/pop: write the slot at sp and move sp; refused ops change nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (push && !full) begin
            r_stack[r_sp[PTR_W-1:0]] <= push_data;
            r_sp                     <= r_sp + CNT_W'(1);
        end else if (pop && !empty) begin
            r_sp <= w_sp_m1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_resp
// Description : Responder for the core's load/store/stack port. Accepts one
//               request at a time, commits its side effect on the accept
//               edge, and holds a single registered response until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_resp
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [7:0]                     req_op,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_full,
    output logic                           stack_empty
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;

    resp_state_t       r_state;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic              w_accept;
    logic              w_is_push;
    logic              w_is_pop;
    logic              w_push_err;
    logic              w_pop_err;
    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_rdata;
    logic              w_err;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_is_push = w_accept && (req_op == OP_PUSH);
    assign w_is_pop  = w_accept && (req_op == OP_POP);

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    mips_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_is_push),
        .pop       (w_is_pop),
        .push_data (req_wdata),
        .top_data  (w_top),
        .push_err  (w_push_err),
        .pop_err   (w_pop_err),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // Response value computed from the pre-commit state of memory and stack
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        case (req_op)
            OP_LOAD: w_rdata = r_mem[req_addr];
            OP_STR:  w_err   = 1'b0;
            OP_PUSH: w_err   = w_push_err;
            OP_POP: begin
                w_err   = w_pop_err;
                w_rdata = w_pop_err ? '0 : w_top;
            end
            default: w_err   = 1'b1;
        endcase
    end

    // Data memory: stores commit on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && (req_op == OP_STR)) begin
            r_mem[req_addr] <= req_wdata;
        end
    end

    // Handshake FSM; response registers are only loaded on accept so they stay stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_rdata <= w_rdata;
                        r_err   <= w_err;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem_resp
// Description : Self-checking bench for mips_mem_resp: directed scenarios
//               followed by random traffic against a queue/array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_resp;
    import mips_pkg::*;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int STACK_DEPTH = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [7:0]           req_op = 8'h0;
    logic [ADDR_W-1:0]    req_addr = '0;
    logic [DATA_W-1:0]    req_wdata = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [DATA_W-1:0]    rsp_rdata;
    logic                 rsp_err;
    logic [5:0]           stack_count;
    logic                 stack_full;
    logic                 stack_empty;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] ref_stk [$];

    mips_mem_resp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = '0;
        ref_stk.delete();
    endtask

    task automatic check_stack_flags(input string tag);
        check_val({tag, "_count"}, 64'(stack_count), 64'(ref_stk.size()));
        check_val({tag, "_full"},  64'(stack_full),  64'(ref_stk.size() == STACK_DEPTH));
        check_val({tag, "_empty"}, 64'(stack_empty), 64'(ref_stk.size() == 0));
    endtask

    // One full transaction: issue, check the response, hold it for 'hold' cycles, then take it
    task automatic do_req(input logic [7:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input int hold);
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
        exp_rd  = '0;
        exp_err = 1'b0;
        if (op == OP_LOAD) begin
            exp_rd = ref_mem[addr];
        end else if (op == OP_STR) begin
            ref_mem[addr] = wd;
        end else if (op == OP_PUSH) begin
            if (ref_stk.size() == STACK_DEPTH) exp_err = 1'b1;
            else ref_stk.push_back(wd);
        end else if (op == OP_POP) begin
            if (ref_stk.size() == 0) exp_err = 1'b1;
            else exp_rd = ref_stk.pop_back();
        end else begin
            exp_err = 1'b1;
        end

        @(negedge clk);
        check_val("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 8'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        check_val("rsp_valid", 64'(rsp_valid), 64'd1);
        check_val("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check_val("rsp_err",   64'(rsp_err),   64'(exp_err));
        check_val("req_ready_resp", 64'(req_ready), 64'd0);
        check_stack_flags("stk");
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("hold_valid", 64'(rsp_valid), 64'd1);
            check_val("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
            check_val("hold_err",   64'(rsp_err),   64'(exp_err));
            check_val("hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("post_hs_valid", 64'(rsp_valid), 64'd0);
        check_val("post_hs_ready", 64'(req_ready), 64'd1);
    endtask

    function automatic logic [7:0] rand_illegal_op();
        logic [7:0] op;
        op = 8'($urandom);
        while (op == OP_LOAD || op == OP_STR || op == OP_PUSH || op == OP_POP)
            op = 8'($urandom);
        return op;
    endfunction

    initial begin
        model_clear();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_val("rst_rsp_err",   64'(rsp_err),   64'd0);
        check_stack_flags("rst");
        rst_n = 1'b1;

        // Store then load back, plus an untouched address
        do_req(OP_STR,  5'd5, 32'hDEADBEEF, 0);
        do_req(OP_LOAD, 5'd5, 32'h0, 0);
        do_req(OP_LOAD, 5'd6, 32'h0, 0);

        // LIFO ordering
        do_req(OP_PUSH, '0, 32'd1, 0);
        do_req(OP_PUSH, '0, 32'd2, 0);
        do_req(OP_PUSH, '0, 32'd3, 0);
        repeat (3) do_req(OP_POP, '0, 32'h0, 0);

        // Fill, overflow, then drain to empty
        for (int i = 0; i < STACK_DEPTH; i++) do_req(OP_PUSH, '0, 32'h1000 + 32'(i), 0);
        do_req(OP_PUSH, '0, 32'hBAD0BAD0, 0);
        for (int i = 0; i < STACK_DEPTH; i++) do_req(OP_POP, '0, 32'h0, 0);

        // Underflow, illegal opcodes, and memory untouched afterwards
        do_req(OP_POP, '0, 32'h0, 0);
        do_req(8'h04, 5'd5, 32'h12345678, 0);
        do_req(OP_NOOP, 5'd5, 32'h12345678, 0);
        do_req(OP_LOAD, 5'd5, 32'h0, 0);

        // Backpressure on a load
        do_req(OP_LOAD, 5'd5, 32'h0, 5);

        // Reset while a PUSH response is pending
        for (int i = 0; i < 4; i++) do_req(OP_PUSH, '0, 32'hA0 + 32'(i), 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_PUSH;
        req_wdata = 32'hCAFE;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        check_val("mid_count",     64'(stack_count), 64'd5);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_val("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("arst_req_ready", 64'(req_ready), 64'd1);
        check_stack_flags("arst");
        @(negedge clk);
        rst_n = 1'b1;
        do_req(OP_LOAD, 5'd5, 32'h0, 0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int sel;
            logic [7:0] op;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)       op = OP_LOAD;
            else if (sel < 4)  op = OP_STR;
            else if (sel < 6)  op = OP_PUSH;
            else if (sel < 9)  op = OP_POP;
            else               op = rand_illegal_op();
            do_req(op, ADDR_W'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mem_resp.md
# mips_mem_resp

Responder side of the core's load/store/stack port. Accepts one request at a time from the mips core over a valid/ready channel and executes it against a 32×32-bit data memory or a 32-entry hardware stack. It returns exactly one response per request over a second valid/ready channel. The core is the initiator; this block owns all data-memory and stack state.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 5, data-memory address width (depth 2**ADDR_W)
- STACK_DEPTH, 32, stack entries (power of two)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_op  in  8  opcode: LOAD 8'h1, STR 8'h3, PUSH 8'hA, POP 8'hB
- req_addr  in  ADDR_W  memory address (LOAD/STR only)
- req_wdata  in  DATA_W  store/push data
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator takes response
- rsp_rdata  out  DATA_W  LOAD/POP data; 0 for STR/PUSH/error
- rsp_err  out  1  overflow, underflow or illegal opcode
- stack_count  out  $clog2(STACK_DEPTH)+1  live entries
- stack_full  out  1  stack_count == STACK_DEPTH
- stack_empty  out  1  stack_count == 0

## Operation
- FSM states: IDLE, RESP.
- IDLE: req_ready=1. On req_valid, latch op/addr/wdata, perform side effect, go to RESP.
- RESP: req_ready=0, rsp_valid=1. Response fields are held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- LOAD: rsp_rdata=mem[req_addr], err=0.
- STR: mem[req_addr]<=req_wdata, rsp_rdata=0, err=0.
- PUSH when not full: stack[sp]<=req_wdata, sp<=sp+1, err=0. When full: no write, sp unchanged, err=1.
- POP when not empty: rsp_rdata=stack[sp-1], sp<=sp-1, err=0. When empty: rdata=0, sp unchanged, err=1.
- Any other opcode (including NOOP 8'h0 and ALU/JMP ops): no side effect, rdata=0, err=1.
- sp is $clog2(STACK_DEPTH)+1 bits wide, so full and empty are unambiguous. stack_count equals sp.
- Addresses always wrap inside ADDR_W. No out-of-range case exists.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stack_count=0, stack_empty=1, stack_full=0. All memory and stack words are cleared to 0.
- Latency: the request is accepted on edge N, and rsp_valid is high from after edge N until the handshake edge. With rsp_ready tied high, the minimum latency is 1 cycle.
- Throughput: at most one request per 2 cycles. A new request is never accepted in the same cycle as a response handshake.
- Side effects (memory write, sp update) commit on the accept edge, not on the response edge.
- stack_count, stack_full and stack_empty reflect the committed sp from the edge after accept.
- Reset asserted mid-transaction discards the pending response, returns to IDLE and clears all state.
- Backpressure: rsp_rdata and rsp_err must not change while rsp_valid && !rsp_ready.

## Structure
- Shared package mips_pkg: opcode constants (NOOP, LOAD, LDNM, STR, ADD, SUB, XOR, AND, JMP, JMP0, PUSH, POP as 8-bit values) and a state enum type. The core is to import the same package.
- Sub-module mips_stack: the LIFO array, sp, full/empty logic, and push/pop with error flags. mips_mem_resp holds the FSM, the data memory, and response muxing.

## Test plan
- STR addr 5 data 32'hDEADBEEF, then LOAD addr 5 -> rsp_rdata=32'hDEADBEEF, err=0; LOAD addr 6 -> 0.
- PUSH 1, 2, 3, then POP×3 -> rdata 3, 2, 1; stack_count goes 3→0; stack_empty=1 at end.
- 32 PUSHes -> stack_full=1. 33rd PUSH -> err=1, count stays 32. POP -> returns the 32nd value, err=0.
- POP on empty stack -> err=1, rdata=0, count=0. Opcode 8'h4 -> err=1, memory and stack unchanged.
- Hold rsp_ready=0 for 5 cycles after a LOAD -> rsp_valid, rdata and err stable, req_ready=0. Release -> handshake, req_ready=1 on the next cycle.
- Push 4 entries, issue a PUSH and assert rst_n=0 while in RESP -> rsp_valid=0 immediately, count=0, and a subsequent LOAD of a previously stored address returns 0.
